// File: rtl/glyph_plotter_pkg.sv
// Shared constants and FSM encoding for the glyph plotter.
package glyph_plotter_pkg;
    localparam int GLYPH_W = 128;
    localparam int CELL_W  = 8;
    localparam int CELL_H  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    localparam logic [2:0] COLOUR_BLACK = 3'd0;
    localparam logic [2:0] COLOUR_WHITE = 3'd7;
endpackage

// File: rtl/glyph_plotter.sv
// Rasterises one 8x16 glyph into a character cell, one framebuffer pixel per clock.
module glyph_plotter
    import glyph_plotter_pkg::*;
#(
    parameter int COLS = 40,
    parameter int ROWS = 15,
    parameter int XW   = 9,
    parameter int YW   = 8,
    parameter int CW   = 3
) (
    input  logic               i_clk,
    input  logic               i_resetn,
    input  logic               i_start,
    input  logic [GLYPH_W-1:0] i_glyph,
    input  logic [5:0]         i_char_col,
    input  logic [4:0]         i_char_row,
    input  logic [CW-1:0]      i_fg,
    input  logic [CW-1:0]      i_bg,
    input  logic               i_bg_en,
    output logic [XW-1:0]      o_x,
    output logic [YW-1:0]      o_y,
    output logic [CW-1:0]      o_colour,
    output logic               o_plot,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err
);
    localparam logic [5:0] COLS_L = 6'(COLS);
    localparam logic [4:0] ROWS_L = 5'(ROWS);

    state_t             r_state;
    logic [GLYPH_W-1:0] r_shift;
    logic [6:0]         r_p;
    logic [5:0]         r_col;
    logic [4:0]         r_row;
    logic [CW-1:0]      r_fg;
    logic [CW-1:0]      r_bg;
    logic               r_bg_en;
    logic               r_err_flag;
    logic [XW-1:0]      r_x;
    logic [YW-1:0]      r_y;
    logic [CW-1:0]      r_colour;
    logic               r_plot;
    logic               r_busy;
    logic               r_done;
    logic               r_err;

    logic [XW-1:0]      w_x;
    logic [YW-1:0]      w_y;
    logic               w_bit;

    // Cell sizes are powers of two, so the pixel address is a plain concatenation.
    assign w_x   = XW'({r_col, r_p[2:0]});
    assign w_y   = YW'({r_row, r_p[6:3]});
    assign w_bit = r_shift[GLYPH_W-1];

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_p        <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_fg       <= '0;
            r_bg       <= '0;
            r_bg_en    <= 1'b0;
            r_err_flag <= 1'b0;
            r_x        <= '0;
            r_y        <= '0;
            r_colour   <= '0;
            r_plot     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_plot <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // The DONE cycle still counts as finishing, so START there is dropped.
                    if (i_start && !r_done) begin
                        r_shift <= i_glyph;
                        r_col   <= i_char_col;
                        r_row   <= i_char_row;
                        r_fg    <= i_fg;
                        r_bg    <= i_bg;
                        r_bg_en <= i_bg_en;
                        r_p     <= '0;
                        r_busy  <= 1'b1;
                        if (i_char_col >= COLS_L || i_char_row >= ROWS_L) begin
                            r_err_flag <= 1'b1;
                            r_state    <= ST_FIN;
                        end else begin
                            r_err_flag <= 1'b0;
                            r_state    <= ST_DRAW;
                        end
                    end
                end
                ST_DRAW: begin
                    if (w_bit || r_bg_en) begin
                        r_x      <= w_x;
                        r_y      <= w_y;
                        r_colour <= w_bit ? r_fg : r_bg;
                        r_plot   <= 1'b1;
                    end
                    r_shift <= {r_shift[GLYPH_W-2:0], 1'b0};
                    r_p     <= r_p + 7'd1;
                    if (r_p == 7'd127) r_state <= ST_FIN;
                end
                ST_FIN: begin
                    r_done  <= 1'b1;
                    r_err   <= r_err_flag;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_x      = r_x;
    assign o_y      = r_y;
    assign o_colour = r_colour;
    assign o_plot   = r_plot;
    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_err    = r_err;
endmodule

// File: tb/tb_glyph_plotter.sv
// Scoreboard bench for glyph_plotter: expected pixels queued at START, popped on PLOT.
module tb_glyph_plotter;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_start;
    logic [127:0] i_glyph;
    logic [5:0]   i_char_col;
    logic [4:0]   i_char_row;
    logic [2:0]   i_fg, i_bg;
    logic         i_bg_en;
    logic [8:0]   o_x;
    logic [7:0]   o_y;
    logic [2:0]   o_colour;
    logic         o_plot, o_busy, o_done, o_err;

    typedef struct {
        int x;
        int y;
        int c;
        int off;
    } exp_t;

    exp_t q[$];
    int   checks = 0, failures = 0;
    int   cyc = 0, s0 = 0, plot_cnt = 0, done_cnt = 0;

    localparam logic [127:0] G_CORNERS = {1'b1, 126'b0, 1'b1};
    localparam logic [127:0] G_A       = 128'h0018_2442_427E_4242_4242_4200_0000_0000;

    glyph_plotter #(.COLS(40), .ROWS(15), .XW(9), .YW(8), .CW(3)) dut (
        .i_clk(clk), .i_resetn(rst_n), .i_start(i_start), .i_glyph(i_glyph),
        .i_char_col(i_char_col), .i_char_row(i_char_row), .i_fg(i_fg), .i_bg(i_bg),
        .i_bg_en(i_bg_en), .o_x(o_x), .o_y(o_y), .o_colour(o_colour), .o_plot(o_plot),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (o_plot) begin
            plot_cnt++;
            if (q.size() == 0) chk("plot_unexpected", 32'(o_plot), 32'd0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("px_x", 32'(o_x), 32'(e.x));
                chk("px_y", 32'(o_y), 32'(e.y));
                chk("px_colour", 32'(o_colour), 32'(e.c));
                chk("px_cycle", 32'(cyc - s0), 32'(e.off));
            end
        end
        if (o_done) done_cnt++;
        if (o_err && !o_done) chk("err_without_done", 32'(o_err), 32'd0);
    end

    task automatic start_draw(input logic [127:0] g, input int col, input int row,
                              input int fg, input int bg, input logic bgen);
        logic b;
        @(posedge clk); #1;
        i_glyph = g; i_char_col = 6'(col); i_char_row = 5'(row);
        i_fg = 3'(fg); i_bg = 3'(bg); i_bg_en = bgen; i_start = 1'b1;
        s0 = cyc; plot_cnt = 0;
        if (col < 40 && row < 15)
            for (int p = 0; p < 128; p++) begin
                b = g[127-p];
                if (b || bgen) q.push_back('{col*8 + p%8, row*16 + p/8, b ? fg : bg, p + 2});
            end
        @(posedge clk); #1;
        i_start = 1'b0;
        i_glyph = {$urandom, $urandom, $urandom, $urandom};
        i_char_col = 6'($urandom); i_char_row = 5'($urandom);
        i_fg = 3'($urandom); i_bg = 3'($urandom); i_bg_en = 1'($urandom);
        chk("busy_cycle1", 32'(o_busy), 32'd1);
    endtask

    task automatic wait_done(input int off, input logic err, input int nplots);
        bit seen = 0;
        for (int n = 0; n < 400 && !seen; n++) begin
            @(negedge clk);
            if (o_done) seen = 1;
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
        else begin
            chk("done_cycle", 32'(cyc - s0), 32'(off));
            chk("done_err", 32'(o_err), 32'(err));
            chk("busy_at_done", 32'(o_busy), 32'd0);
        end
        #1;
        chk("plot_count", 32'(plot_cnt), 32'(nplots));
        chk("queue_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        int base;
        rst_n = 1'b0; i_start = 1'b0; i_glyph = '0; i_char_col = '0; i_char_row = '0;
        i_fg = '0; i_bg = '0; i_bg_en = 1'b0;
        #12;
        chk("rst_outputs", {o_x, o_y, o_colour, o_plot, o_busy, o_done, o_err}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // two corner pixels, transparent background
        start_draw(G_CORNERS, 2, 3, 7, 0, 1'b0);
        wait_done(130, 1'b0, 2);

        // blank glyph, opaque background fills the whole cell
        start_draw('0, 0, 0, 5, 1, 1'b1);
        wait_done(130, 1'b0, 128);

        // 'A' in the bottom-right cell
        start_draw(G_A, 39, 14, 2, 0, 1'b0);
        wait_done(130, 1'b0, 24);
        chk("popcount_A", 32'($countones(G_A)), 32'd24);

        // out-of-range column and row
        start_draw(G_A, 40, 0, 2, 0, 1'b1);
        wait_done(2, 1'b1, 0);
        start_draw(G_A, 0, 15, 2, 0, 1'b1);
        wait_done(2, 1'b1, 0);
        @(negedge clk);
        chk("busy_after_err", 32'(o_busy), 32'd0);

        // second START mid-draw is dropped; START right after DONE is taken
        base = done_cnt;
        start_draw(G_CORNERS, 5, 6, 3, 0, 1'b0);
        repeat (49) @(posedge clk);
        #1; i_start = 1'b1; i_glyph = '1; i_char_col = 6'd1; i_bg_en = 1'b1;
        @(posedge clk); #1; i_start = 1'b0;
        wait_done(130, 1'b0, 2);
        chk("single_done", 32'(done_cnt - base), 32'd1);
        start_draw(G_A, 10, 7, 6, 1, 1'b1);
        wait_done(130, 1'b0, 128);

        // asynchronous reset mid-draw
        base = done_cnt;
        start_draw(G_A, 3, 4, 4, 2, 1'b1);
        repeat (59) @(posedge clk);
        #1; rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", {o_x, o_y, o_colour, o_plot, o_busy, o_done, o_err}, 32'd0);
        q.delete();
        repeat (3) @(posedge clk);
        #1; rst_n = 1'b1;
        repeat (2) @(posedge clk);
        chk("no_done_after_rst", 32'(done_cnt - base), 32'd0);
        start_draw(G_CORNERS, 7, 2, 5, 0, 1'b0);
        wait_done(130, 1'b0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
